reg_bank_writer: RTL

//  Write side of the processor register bank: the complement of the 8-to-1 16-bit read mux.

---
 rtl/reg_bank_writer.sv | 89 ++++++++
 1 files changed

// File: rtl/reg_bank_writer.sv
// Write side of the register bank: a small in-order write queue drained one entry
// per cycle into eight registers R0..R7 that feed the read mux.
module reg_bank_writer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     hold,
   input  logic                     wr_valid,
   input  logic [2:0]               wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_ready,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         r0,
   output logic [WIDTH-1:0]         r1,
   output logic [WIDTH-1:0]         r2,
   output logic [WIDTH-1:0]         r3,
   output logic [WIDTH-1:0]         r4,
   output logic [WIDTH-1:0]         r5,
   output logic [WIDTH-1:0]         r6,
   output logic [WIDTH-1:0]         r7
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [2:0]       q_addr [DEPTH];
   logic [WIDTH-1:0] q_data [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [WIDTH-1:0] bank [8];
   logic             push;
   logic             pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign wr_ready = !full;

   // clear wins over everything, so it also vetoes the handshake and the drain
   assign push = wr_valid && wr_ready && !clear;
   assign pop  = !empty && !hold && !clear;

   // NOTE: queue storage has no reset; head/tail/count decide which slots are live,
   // so stale contents are never observed and the RAM stays reset-free.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[tail] <= wr_addr;
         q_data[tail] <= wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < 8; i++) bank[i] <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < 8; i++) bank[i] <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop) begin
            head               <= head + PW'(1);
            bank[q_addr[head]] <= q_data[head];
         end
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   assign r0 = bank[0];
   assign r1 = bank[1];
   assign r2 = bank[2];
   assign r3 = bank[3];
   assign r4 = bank[4];
   assign r5 = bank[5];
   assign r6 = bank[6];
   assign r7 = bank[7];

endmodule
